// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract sequencer sharing one full-adder cell
// Ports: clk, rst_n (async active-low); start/mode/a/b request in;
//        busy (RUN), done (1-cycle pulse), result/cout/overflow (registered, held until next done)
module fadder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ cin;
  assign co = (x & y) | (cin & (x ^ y));
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, acc;
  logic [CW-1:0] cnt;
  logic carry, s, co, accept, last;
  fadder u_fa (.x(a_sr[0]), .y(b_sr[0]), .cin(carry), .s(s), .co(co));
  assign accept = start && state != RUN;
  assign last   = cnt == CW'(WIDTH - 1);
  assign busy   = state == RUN;
  assign done   = state == DONE;
  always_comb begin
    state_nx = IDLE;
    state_nx = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // subtract runs as a + ~b + 1: b is inverted on load and the carry seeded with 1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      acc      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= mode ? ~b : b;
      carry <= mode;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      acc   <= {s, acc[WIDTH-1:1]};
      carry <= co;
      cnt   <= cnt + 1'b1;
      // on the last bit, carry holds the carry into the MSB
      if (last) begin
        result   <= {s, acc[WIDTH-1:1]};
        cout     <= co;
        overflow <= carry ^ co;
      end
    end
endmodule
